// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbitration bus: per-master requests/locks, owner transfer info,
// slave response, and the arbiter's grant/master/lock outputs.
interface ahb_bus_arbiter_if #(
    parameter int unsigned NUM_MST = 4
);
    logic [NUM_MST-1:0] hbusreq;
    logic [NUM_MST-1:0] hlock;
    logic [1:0]         htrans;
    logic [2:0]         hburst;
    logic               hready;
    logic [1:0]         hresp;
    logic [NUM_MST-1:0] hgrant;
    logic [3:0]         hmaster;
    logic               hmastlock;

    // Requesting side: masters plus slave response feeding the arbiter
    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp,
        input  hgrant, hmaster, hmastlock
    );

    // Arbiter side
    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: shares one slave port between NUM_MST masters,
// holding the grant through fixed-length bursts and locked sequences.
module ahb_bus_arbiter #(
    parameter int unsigned NUM_MST = 4,
    parameter int unsigned DEF_MST = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_bus_arbiter_if.slave  bus
);
    localparam int unsigned REM_W = 5;
    localparam int unsigned IDX_W = 4;
    localparam int          N_MST = int'(NUM_MST);

    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [1:0] HRESP_OKAY    = 2'd0;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t             state_q;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   burst_len_m1;
    logic [REM_W-1:0]   nxt_rem;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   hmaster_q;
    logic [IDX_W-1:0]   rr_winner;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_MST-1:0] hgrant_q;
    logic               hmastlock_q;
    logic               hold_lock;
    logic               arb_ok;
    logic               rr_found;
    logic               grant_lock;
    int                 rr_best;
    int                 rr_dist;

    // Beats remaining after the NONSEQ beat of a burst of type hburst
    always_comb begin
        case (bus.hburst)
            3'd2, 3'd3: burst_len_m1 = REM_W'(3);
            3'd4, 3'd5: burst_len_m1 = REM_W'(7);
            3'd6, 3'd7: burst_len_m1 = REM_W'(15);
            default:    burst_len_m1 = '0;
        endcase
    end

    // Beat counter value the next accepted edge would load; a non-OKAY response ends the burst
    always_comb begin
        nxt_rem = rem_q;
        if (bus.hresp != HRESP_OKAY) begin
            nxt_rem = '0;
        end else if (bus.htrans == HTRANS_NONSEQ) begin
            nxt_rem = burst_len_m1;
        end else if (bus.htrans == HTRANS_SEQ && rem_q != '0) begin
            nxt_rem = rem_q - REM_W'(1);
        end
    end

    // Owner of the address phase keeps the bus while it locks, requests and is granted
    always_comb begin
        hold_lock = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (IDX_W'(i) == hmaster_q) begin
                hold_lock = bus.hlock[i] & bus.hbusreq[i] & hgrant_q[i];
            end
        end
    end

    // Index and lock request of the currently granted master (grant is one-hot)
    always_comb begin
        grant_idx  = '0;
        grant_lock = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (hgrant_q[i]) begin
                grant_idx  = IDX_W'(i);
                grant_lock = bus.hlock[i];
            end
        end
    end

    // Round-robin pick: closest requester after last, wrapping; last itself is searched last
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = IDX_W'(DEF_MST);
        rr_best   = N_MST;
        rr_dist   = 0;
        for (int i = 0; i < N_MST; i++) begin
            rr_dist = (i + 2 * N_MST - int'(last_q) - 1) % N_MST;
            if (bus.hbusreq[i] && rr_dist < rr_best) begin
                rr_best   = rr_dist;
                rr_winner = IDX_W'(i);
                rr_found  = 1'b1;
            end
        end
    end

    assign arb_ok = bus.hready & (nxt_rem == '0) & ~hold_lock;

    // Arbitration state, beat counter and registered bus outputs; everything holds while hready=0
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_ARB;
            rem_q       <= '0;
            last_q      <= IDX_W'(DEF_MST);
            hgrant_q    <= NUM_MST'(1) << DEF_MST;
            hmaster_q   <= IDX_W'(DEF_MST);
            hmastlock_q <= 1'b0;
        end else if (bus.hready) begin
            rem_q       <= nxt_rem;
            hmaster_q   <= grant_idx;
            hmastlock_q <= grant_lock;

            case (state_q)
                ST_ARB: begin
                    if (hold_lock) begin
                        state_q <= ST_LOCK;
                    end else if (bus.htrans == HTRANS_NONSEQ && bus.hresp == HRESP_OKAY
                                 && burst_len_m1 != '0) begin
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (hold_lock) begin
                        state_q <= ST_LOCK;
                    end else if (nxt_rem == '0 || bus.hresp != HRESP_OKAY) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_LOCK: begin
                    if (!hold_lock) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase

            if (arb_ok && state_q != ST_LOCK) begin
                hgrant_q <= NUM_MST'(1) << rr_winner;
                if (rr_found) begin
                    last_q <= rr_winner;
                end
            end
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule
